// File: rtl/kernel_onchip_ram_arb.sv
// Dual Avalon-MM slave front end sharing one single-port on-chip RAM.
// Round-robin arbitration with a tagged, pipelined read return per port.
module kernel_onchip_ram_arb #(
    parameter int    DATA_WIDTH   = 32,
    parameter int    ADDR_WIDTH   = 11,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = "kernel_onchip_ram.hex"
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic [ADDR_WIDTH-1:0]   s1_address,
    input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
    input  logic                    s1_chipselect,
    input  logic                    s1_read,
    input  logic                    s1_write,
    input  logic [DATA_WIDTH-1:0]   s1_writedata,
    output logic                    s1_waitrequest,
    output logic [DATA_WIDTH-1:0]   s1_readdata,
    output logic                    s1_readdatavalid,

    input  logic [ADDR_WIDTH-1:0]   s2_address,
    input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
    input  logic                    s2_chipselect,
    input  logic                    s2_read,
    input  logic                    s2_write,
    input  logic [DATA_WIDTH-1:0]   s2_writedata,
    output logic                    s2_waitrequest,
    output logic [DATA_WIDTH-1:0]   s2_readdata,
    output logic                    s2_readdatavalid
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int L     = READ_LATENCY;

    logic                  req1;
    logic                  req2;
    logic                  grant1;
    logic                  grant2;
    logic                  last_grant_q;
    logic                  last_grant_d;

    logic                  acc_wr;
    logic                  acc_rd;
    logic                  acc_port;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [BE_W-1:0]       acc_be;
    logic [DATA_WIDTH-1:0] acc_wdata;

    logic [L-1:0]          tag_v_q;
    logic [L-1:0]          tag_v_d;
    logic [L-1:0]          tag_p_q;
    logic [L-1:0]          tag_p_d;
    logic [DATA_WIDTH-1:0] dat_q [L];

    logic                  out_v1;
    logic                  out_v2;
    logic [DATA_WIDTH-1:0] rdata1_q;
    logic [DATA_WIDTH-1:0] rdata1_d;
    logic [DATA_WIDTH-1:0] rdata2_q;
    logic [DATA_WIDTH-1:0] rdata2_d;

    // The image is attached through the RAM inference attribute, not at reset.
    (* ram_init_file = INIT_FILE *)
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // last_grant_q: 0 = s1 was last granted, 1 = s2.
    always_comb begin
        req1   = s1_chipselect & (s1_read | s1_write);
        req2   = s2_chipselect & (s2_read | s2_write);
        grant1 = req1 & (~req2 | last_grant_q);
        grant2 = req2 & ~grant1;

        last_grant_d = last_grant_q;
        if (grant1) begin
            last_grant_d = 1'b0;
        end else if (grant2) begin
            last_grant_d = 1'b1;
        end

        acc_port  = grant2;
        acc_addr  = grant2 ? s2_address    : s1_address;
        acc_be    = grant2 ? s2_byteenable : s1_byteenable;
        acc_wdata = grant2 ? s2_writedata  : s1_writedata;
        acc_wr    = (grant1 & s1_write) | (grant2 & s2_write);
        acc_rd    = (grant1 & s1_read & ~s1_write)
                  | (grant2 & s2_read & ~s2_write);
    end

    assign s1_waitrequest = req1 & ~grant1;
    assign s2_waitrequest = req2 & ~grant2;

    always_comb begin
        tag_v_d    = '0;
        tag_p_d    = '0;
        tag_v_d[0] = acc_rd;
        tag_p_d[0] = acc_port;
        for (int i = 1; i < L; i++) begin
            tag_v_d[i] = tag_v_q[i-1];
            tag_p_d[i] = tag_p_q[i-1];
        end
    end

    always_comb begin
        out_v1   = tag_v_q[L-1] & ~tag_p_q[L-1];
        out_v2   = tag_v_q[L-1] &  tag_p_q[L-1];
        rdata1_d = out_v1 ? dat_q[L-1] : rdata1_q;
        rdata2_d = out_v2 ? dat_q[L-1] : rdata2_q;
    end

    assign s1_readdatavalid = out_v1;
    assign s2_readdatavalid = out_v2;
    assign s1_readdata      = rdata1_d;
    assign s2_readdata      = rdata2_d;

    // Reset flushes in-flight tags so aborted reads never return.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= 1'b1;
            tag_v_q      <= '0;
            tag_p_q      <= '0;
            rdata1_q     <= '0;
            rdata2_q     <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            tag_v_q      <= tag_v_d;
            tag_p_q      <= tag_p_d;
            rdata1_q     <= rdata1_d;
            rdata2_q     <= rdata2_d;
        end
    end

    always_ff @(posedge clk) begin
        if (acc_wr) begin
            for (int b = 0; b < BE_W; b++) begin
                if (acc_be[b]) begin
                    mem[acc_addr][b*8 +: 8] <= acc_wdata[b*8 +: 8];
                end
            end
        end
        if (acc_rd) begin
            dat_q[0] <= mem[acc_addr];
        end
        for (int i = 1; i < L; i++) begin
            dat_q[i] <= dat_q[i-1];
        end
    end

endmodule
